// File: rtl/multicycle_ctrl_v2_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// The controller uses the master modport; the datapath uses the slave modport.
interface multicycle_ctrl_v2_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             fetch_stall;
  logic             mem_ready;
  logic [2:0]       state;
  logic [3:0]       ALUCtrl;
  logic             ALUSrc;
  logic             alu_a_pc;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       wb_sel;
  logic [1:0]       pc_sel;
  logic             loadPC;
  logic             retire;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, zero, lt, ltu, fetch_stall, mem_ready,
    output state, ALUCtrl, ALUSrc, alu_a_pc, MemRead, MemWrite, RegWrite,
           wb_sel, pc_sel, loadPC, retire, trap, instret
  );

  modport slave (
    output instr, zero, lt, ltu, fetch_stall, mem_ready,
    input  state, ALUCtrl, ALUSrc, alu_a_pc, MemRead, MemWrite, RegWrite,
           wb_sel, pc_sel, loadPC, retire, trap, instret
  );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing with memory timeout,
// illegal-instruction trap and a retired-instruction counter.
module multicycle_ctrl_v2 #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_v2_if.master bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic               taken_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   instret_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] alu_res;
  logic       dec_legal, dec_alusrc, dec_apc, dec_regw, dec_load, dec_store, dec_branch;
  logic [3:0] dec_alu;
  logic [1:0] dec_wbsel, dec_pcsel;
  logic       mem_timeout;
  logic       unused_instr_bits;

  // Returns {legal, alu_ctrl}; immediate forms ignore funct7 except for shifts.
  function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_imm);
    logic       f7_zero, f7_alt, legal;
    logic [3:0] ctrl;
    f7_zero = (f7 == 7'b0000000);
    f7_alt  = (f7 == 7'b0100000);
    legal   = 1'b1;
    ctrl    = ALU_ADD;
    case (f3)
      3'b000: if (is_imm || f7_zero) ctrl = ALU_ADD;
              else if (f7_alt) ctrl = ALU_SUB;
              else legal = 1'b0;
      3'b001: begin ctrl = ALU_SLL;  legal = f7_zero; end
      3'b010: begin ctrl = ALU_SLT;  legal = is_imm || f7_zero; end
      3'b011: begin ctrl = ALU_SLTU; legal = is_imm || f7_zero; end
      3'b100: begin ctrl = ALU_XOR;  legal = is_imm || f7_zero; end
      3'b101: if (f7_zero) ctrl = ALU_SRL;
              else if (f7_alt) ctrl = ALU_SRA;
              else legal = 1'b0;
      3'b110: begin ctrl = ALU_OR;   legal = is_imm || f7_zero; end
      default: begin ctrl = ALU_AND; legal = is_imm || f7_zero; end
    endcase
    return {legal, ctrl};
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic slt, input logic sltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return slt;
      3'b101:  return !slt;
      3'b110:  return sltu;
      3'b111:  return !sltu;
      default: return 1'b0;
    endcase
  endfunction

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7            = bus.instr[31:25];
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};
  assign alu_res           = alu_decode(funct3, funct7, opcode == OPC_OPIMM);
  assign mem_timeout       = TIMEOUT_EN && (wait_q == WAIT_LAST);

  always_comb begin
    dec_legal  = 1'b1;
    dec_alu    = ALU_ADD;
    dec_alusrc = 1'b0;
    dec_apc    = 1'b0;
    dec_regw   = 1'b1;
    dec_wbsel  = 2'b00;
    dec_pcsel  = 2'b00;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    case (opcode)
      OPC_LOAD:   begin dec_alusrc = 1'b1; dec_wbsel = 2'b01; dec_load = 1'b1; end
      OPC_STORE:  begin dec_alusrc = 1'b1; dec_regw = 1'b0; dec_store = 1'b1; end
      OPC_OPIMM:  begin dec_alusrc = 1'b1; dec_alu = alu_res[3:0]; dec_legal = alu_res[4]; end
      OPC_OP:     begin dec_alu = alu_res[3:0]; dec_legal = alu_res[4]; end
      OPC_BRANCH: begin
        dec_alu    = ALU_SUB;
        dec_regw   = 1'b0;
        dec_branch = 1'b1;
        dec_pcsel  = taken_q ? 2'b01 : 2'b00;
        dec_legal  = (funct3[2:1] != 2'b01);
      end
      OPC_JAL:    begin dec_wbsel = 2'b10; dec_pcsel = 2'b01; end
      OPC_JALR:   begin dec_alusrc = 1'b1; dec_wbsel = 2'b10; dec_pcsel = 2'b10; end
      OPC_LUI:    dec_wbsel = 2'b11;
      OPC_AUIPC:  begin dec_alusrc = 1'b1; dec_apc = 1'b1; end
      default:    begin dec_legal = 1'b0; dec_regw = 1'b0; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus.ALUCtrl  = 4'b0000;
    bus.ALUSrc   = 1'b0;
    bus.alu_a_pc = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.pc_sel   = 2'b00;
    bus.loadPC   = 1'b0;
    bus.retire   = 1'b0;
    bus.trap     = 1'b0;
    if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
      bus.ALUCtrl  = dec_alu;
      bus.ALUSrc   = dec_alusrc;
      bus.alu_a_pc = dec_apc;
    end
    case (state_q)
      S_IF:  if (!bus.fetch_stall) state_d = S_ID;
      S_ID:  state_d = dec_legal ? S_EX : S_TRAP;
      S_EX:  state_d = (dec_load || dec_store) ? S_MEM : S_WB;
      S_MEM: begin
        bus.MemRead  = dec_load;
        bus.MemWrite = dec_store;
        // A ready response in the timeout cycle still completes the access.
        if (bus.mem_ready)      state_d = S_WB;
        else if (mem_timeout)   state_d = S_TRAP;
      end
      S_WB: begin
        bus.RegWrite = dec_regw;
        bus.wb_sel   = dec_wbsel;
        bus.pc_sel   = dec_pcsel;
        bus.loadPC   = 1'b1;
        bus.retire   = 1'b1;
        state_d      = S_IF;
      end
      S_TRAP: bus.trap = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      taken_q   <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EX) begin
        taken_q <= dec_branch & branch_taken(funct3, bus.zero, bus.lt, bus.ltu);
        wait_q  <= '0;
      end else if (state_q == S_MEM && !bus.mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end
      if (state_q == S_WB) instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2 with a 4-bit retired-instruction counter.
module tb_multicycle_ctrl_v2;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] exp_instret;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;

  multicycle_ctrl_v2_if #(.CNT_W(4)) bus ();

  multicycle_ctrl_v2 #(.CNT_W(4), .MEM_TIMEOUT(15), .WAIT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] b_type(input logic [2:0] f3);
    return {7'b0, 5'd2, 5'd1, f3, 5'b01000, 7'b1100011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_instret = 4'd0;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", bus.state);
    end
    checks++;
    if ({bus.ALUCtrl, bus.ALUSrc, bus.alu_a_pc, bus.MemRead, bus.MemWrite, bus.RegWrite,
         bus.wb_sel, bus.pc_sel, bus.loadPC, bus.retire, bus.trap} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: control outputs not all zero");
    end
    checks++;
    if (bus.instret !== 4'd0) begin
      errors++; $display("FAIL reset_instret: got %0d expected 0", bus.instret);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi;
    bus.instr = I_ADDI;
    bus.fetch_stall = 1'b0;
    tick;
    checks++;
    if (bus.state !== 3'd1 || bus.ALUCtrl !== 4'b0010) begin
      errors++; $display("FAIL addi_id: state %0d alu %b expected 1 0010", bus.state, bus.ALUCtrl);
    end
    tick;
    checks++;
    if (bus.state !== 3'd2 || bus.ALUSrc !== 1'b1 || bus.ALUCtrl !== 4'b0010) begin
      errors++; $display("FAIL addi_ex: state %0d alusrc %b alu %b expected 2 1 0010",
                         bus.state, bus.ALUSrc, bus.ALUCtrl);
    end
    tick;
    checks++;
    if (bus.state !== 3'd4 || bus.RegWrite !== 1'b1 || bus.wb_sel !== 2'b00 ||
        bus.pc_sel !== 2'b00 || bus.retire !== 1'b1 || bus.loadPC !== 1'b1) begin
      errors++; $display("FAIL addi_wb: state %0d rw %b wb %b pc %b ret %b ld %b expected 4 1 00 00 1 1",
                         bus.state, bus.RegWrite, bus.wb_sel, bus.pc_sel, bus.retire, bus.loadPC);
    end
    exp_instret++;
    tick;
    checks++;
    if (bus.state !== 3'd0 || bus.instret !== exp_instret || bus.retire !== 1'b0) begin
      errors++; $display("FAIL addi_done: state %0d instret %0d retire %b expected 0 %0d 0",
                         bus.state, bus.instret, bus.retire, exp_instret);
    end
  endtask

  task automatic test_fetch_stall;
    bus.instr = I_ADDI;
    bus.fetch_stall = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.state !== 3'd0 || bus.loadPC !== 1'b0 || bus.ALUCtrl !== 4'b0000) begin
      errors++; $display("FAIL stall_hold: state %0d loadPC %b alu %b expected 0 0 0000",
                         bus.state, bus.loadPC, bus.ALUCtrl);
    end
    bus.fetch_stall = 1'b0;
    tick;
    checks++;
    if (bus.state !== 3'd1) begin
      errors++; $display("FAIL stall_release: state %0d expected 1", bus.state);
    end
    repeat (3) tick;
    exp_instret++;
  endtask

  task automatic test_alu_decode;
    logic [31:0] ins [10];
    logic [3:0]  alu [10];
    logic        src [10];
    ins = '{32'h402081B3, 32'h4020D1B3, 32'h4030D093, 32'h0010B093, 32'h002091B3,
            32'h0020F1B3, 32'h0020D1B3, 32'hFFF0C093, 32'hFFF0A093, 32'h0020E1B3};
    alu = '{4'b0110, 4'b1010, 4'b1010, 4'b0011, 4'b1001,
            4'b0000, 4'b1000, 4'b0101, 4'b0100, 4'b0001};
    src = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.instr = ins[i];
      tick;
      tick;
      checks++;
      if (bus.state !== 3'd2 || bus.ALUCtrl !== alu[i] || bus.ALUSrc !== src[i]) begin
        errors++; $display("FAIL alu_decode[%0d]: state %0d alu %b src %b expected 2 %b %b",
                           i, bus.state, bus.ALUCtrl, bus.ALUSrc, alu[i], src[i]);
      end
      tick;
      checks++;
      if (bus.state !== 3'd4 || bus.RegWrite !== 1'b1) begin
        errors++; $display("FAIL alu_wb[%0d]: state %0d rw %b expected 4 1", i, bus.state, bus.RegWrite);
      end
      tick;
      exp_instret++;
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic l,
                             input logic lu, input logic [1:0] exp_pc, input string name);
    bus.instr = b_type(f3);
    bus.zero = z; bus.lt = l; bus.ltu = lu;
    tick;
    tick;
    checks++;
    if (bus.state !== 3'd2 || bus.ALUCtrl !== 4'b0110 || bus.ALUSrc !== 1'b0) begin
      errors++; $display("FAIL %s_ex: state %0d alu %b src %b expected 2 0110 0",
                         name, bus.state, bus.ALUCtrl, bus.ALUSrc);
    end
    tick;
    checks++;
    if (bus.state !== 3'd4 || bus.pc_sel !== exp_pc || bus.RegWrite !== 1'b0 || bus.retire !== 1'b1) begin
      errors++; $display("FAIL %s_wb: state %0d pc_sel %b rw %b ret %b expected 4 %b 0 1",
                         name, bus.state, bus.pc_sel, bus.RegWrite, bus.retire, exp_pc);
    end
    tick;
    exp_instret++;
    bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
  endtask

  task automatic test_lw_wait;
    int exp_st [8];
    int n_read;
    int n_busy;
    exp_st = '{1, 2, 3, 3, 3, 3, 4, 0};
    n_read = 0;
    n_busy = 0;
    bus.instr = I_LW;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.state != 3'd0) n_busy++;
      if (bus.MemRead === 1'b1) n_read++;
      checks++;
      if (bus.state !== 3'(exp_st[i])) begin
        errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, exp_st[i]);
      end
      if (i == 5) bus.mem_ready = 1'b1;
      if (i == 6) begin
        checks++;
        if (bus.wb_sel !== 2'b01 || bus.RegWrite !== 1'b1 || bus.MemRead !== 1'b0) begin
          errors++; $display("FAIL lw_wb: wb_sel %b rw %b mr %b expected 01 1 0",
                             bus.wb_sel, bus.RegWrite, bus.MemRead);
        end
        bus.mem_ready = 1'b0;
      end
    end
    exp_instret++;
    checks++;
    if (n_read != 4 || n_busy != 7) begin
      errors++; $display("FAIL lw_timing: memread cycles %0d busy cycles %0d expected 4 7", n_read, n_busy);
    end
  endtask

  task automatic test_jumps;
    logic [31:0] ins [4];
    logic        src [4];
    logic        apc [4];
    logic [1:0]  wbs [4];
    logic [1:0]  pcs [4];
    ins = '{32'h000080E7, 32'h008000EF, 32'h123450B7, 32'h00001097};
    src = '{1'b1, 1'b0, 1'b0, 1'b1};
    apc = '{1'b0, 1'b0, 1'b0, 1'b1};
    wbs = '{2'b10, 2'b10, 2'b11, 2'b00};
    pcs = '{2'b10, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      bus.instr = ins[i];
      tick;
      tick;
      checks++;
      if (bus.state !== 3'd2 || bus.ALUSrc !== src[i] || bus.alu_a_pc !== apc[i] ||
          bus.ALUCtrl !== 4'b0010) begin
        errors++; $display("FAIL jump_ex[%0d]: state %0d src %b apc %b alu %b expected 2 %b %b 0010",
                           i, bus.state, bus.ALUSrc, bus.alu_a_pc, bus.ALUCtrl, src[i], apc[i]);
      end
      tick;
      checks++;
      if (bus.state !== 3'd4 || bus.wb_sel !== wbs[i] || bus.pc_sel !== pcs[i] ||
          bus.RegWrite !== 1'b1) begin
        errors++; $display("FAIL jump_wb[%0d]: state %0d wb %b pc %b rw %b expected 4 %b %b 1",
                           i, bus.state, bus.wb_sel, bus.pc_sel, bus.RegWrite, wbs[i], pcs[i]);
      end
      tick;
      exp_instret++;
    end
  endtask

  task automatic test_sw_timeout;
    int n_mem;
    int n_wr;
    n_mem = 0;
    n_wr = 0;
    bus.instr = I_SW;
    bus.mem_ready = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.state != 3'd3) break;
      n_mem++;
      if (bus.MemWrite === 1'b1) n_wr++;
    end
    checks++;
    if (n_mem != 15 || n_wr != 15) begin
      errors++; $display("FAIL sw_timeout_len: mem cycles %0d write cycles %0d expected 15 15", n_mem, n_wr);
    end
    checks++;
    if (bus.state !== 3'd7 || bus.trap !== 1'b1 || bus.MemWrite !== 1'b0 ||
        bus.retire !== 1'b0 || bus.loadPC !== 1'b0 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL sw_trap: state %0d trap %b mw %b ret %b ld %b expected 7 1 0 0 0",
                         bus.state, bus.trap, bus.MemWrite, bus.retire, bus.loadPC);
    end
    repeat (3) tick;
    checks++;
    if (bus.state !== 3'd7 || bus.instret !== exp_instret) begin
      errors++; $display("FAIL sw_trap_hold: state %0d instret %0d expected 7 %0d",
                         bus.state, bus.instret, exp_instret);
    end
    pulse_reset;
    checks++;
    if (bus.state !== 3'd0 || bus.trap !== 1'b0 || bus.instret !== 4'd0) begin
      errors++; $display("FAIL trap_reset: state %0d trap %b instret %0d expected 0 0 0",
                         bus.state, bus.trap, bus.instret);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ins [4];
    ins = '{32'h0000007F, 32'h022081B3, b_type(3'b010), 32'h40309093};
    for (int i = 0; i < 4; i++) begin
      bus.instr = ins[i];
      tick;
      tick;
      checks++;
      if (bus.state !== 3'd7 || bus.trap !== 1'b1 || bus.retire !== 1'b0) begin
        errors++; $display("FAIL illegal[%0d]: state %0d trap %b retire %b expected 7 1 0",
                           i, bus.state, bus.trap, bus.retire);
      end
      pulse_reset;
    end
  endtask

  task automatic test_rst_mid_mem;
    bus.instr = I_LW;
    bus.mem_ready = 1'b0;
    repeat (4) tick;
    checks++;
    if (bus.state !== 3'd3 || bus.MemRead !== 1'b1) begin
      errors++; $display("FAIL rst_mem_pre: state %0d mr %b expected 3 1", bus.state, bus.MemRead);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.MemRead !== 1'b0 || bus.retire !== 1'b0 ||
        bus.loadPC !== 1'b0 || bus.instret !== 4'd0) begin
      errors++; $display("FAIL rst_mem: state %0d mr %b ret %b ld %b instret %0d expected 0 0 0 0 0",
                         bus.state, bus.MemRead, bus.retire, bus.loadPC, bus.instret);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_instret = 4'd0;
  endtask

  task automatic test_instret_wrap;
    pulse_reset;
    bus.instr = I_ADDI;
    for (int i = 0; i < 15; i++) repeat (4) tick;
    checks++;
    if (bus.instret !== 4'd15) begin
      errors++; $display("FAIL instret_15: got %0d expected 15", bus.instret);
    end
    repeat (4) tick;
    checks++;
    if (bus.instret !== 4'd0 || bus.state !== 3'd0) begin
      errors++; $display("FAIL instret_wrap: instret %0d state %0d expected 0 0", bus.instret, bus.state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_instret = 4'd0;
    rst = 1'b1;
    bus.instr = 32'h00000013;
    bus.zero = 1'b0;
    bus.lt = 1'b0;
    bus.ltu = 1'b0;
    bus.fetch_stall = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_addi;
    test_fetch_stall;
    test_alu_decode;
    test_branch(3'b001, 1'b0, 1'b0, 1'b0, 2'b01, "bne_taken");
    test_branch(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, "bne_not_taken");
    test_branch(3'b111, 1'b0, 1'b0, 1'b0, 2'b01, "bgeu_taken");
    test_branch(3'b111, 1'b0, 1'b0, 1'b1, 2'b00, "bgeu_not_taken");
    test_branch(3'b100, 1'b0, 1'b1, 1'b0, 2'b01, "blt_taken");
    test_branch(3'b000, 1'b1, 1'b0, 1'b0, 2'b01, "beq_taken");
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++; $display("FAIL instret_count: got %0d expected %0d", bus.instret, exp_instret);
    end
    test_lw_wait;
    test_jumps;
    test_sw_timeout;
    test_illegal;
    test_rst_mid_mem;
    test_instret_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
Second-generation multicycle control FSM for the RV32I core. It sequences IF/ID/EX/MEM/WB and drives datapath control from the held instruction word. It adds five things to the first generation: full branch set, JAL/JALR/LUI/AUIPC, a fetch-stall and memory-ready handshake with timeout, an illegal-instruction trap state, and a retired-instruction counter. It sits between the datapath, the instruction ROM and the data RAM in the top-level processor.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.
MEM_TIMEOUT, 15, maximum MEM cycles waiting for mem_ready before trapping; 0 disables the timeout.
WAIT_W, 4, width of the MEM wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
instr  in  32  instruction word, held stable by the datapath from ID through WB.
zero  in  1  ALU result == 0.
lt  in  1  signed A<B from ALU comparator.
ltu  in  1  unsigned A<B from ALU comparator.
fetch_stall  in  1  instruction memory not ready.
mem_ready  in  1  data memory access complete.
state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
ALUCtrl  out  4  ALU operation.
ALUSrc  out  1  ALU B operand: 1 = immediate.
alu_a_pc  out  1  ALU A operand: 1 = PC (AUIPC).
MemRead  out  1  data read strobe.
MemWrite  out  1  data write strobe.
RegWrite  out  1  register file write enable.
wb_sel  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4, 11 U-immediate.
pc_sel  out  2  next-PC source: 00 PC+4, 01 PC+imm, 10 ALU&~1.
loadPC  out  1  PC register load enable.
retire  out  1  one-cycle pulse when an instruction completes.
trap  out  1  high while in TRAP.
instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous): state=IF; taken_q=0; wait counter=0; instret=0. All control outputs are 0 while in IF.
- Outputs are combinational from state, instr and taken_q. Every output is assigned in every state; there are no latches.
- IF: if fetch_stall=1, stay in IF; otherwise go to ID.
- ID: decode the opcode.
  - Legal opcodes: 0000011 LW, 0100011 SW, 0010011 OP-IMM, 0110011 OP, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode goes to TRAP.
  - A BRANCH with funct3 010 or 011 goes to TRAP.
  - Otherwise go to EX.
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SLTU 0011, SLT 0100, XOR 0101, SUB 0110, SRL 1000, SLL 1001, SRA 1010.
- ALUCtrl assignment, valid from ID through WB:
  - LW, SW, JALR, AUIPC: ADD.
  - BRANCH: SUB.
  - OP and OP-IMM: decoded from funct3/funct7, including SLTU/SLTIU. funct7=0100000 selects SUB (OP only) or SRA/SRAI. Any undefined funct7 combination goes to TRAP.
  - LUI and JAL: ADD, result unused.
- EX:
  - ALUSrc=1 for LW, SW, OP-IMM, JALR, AUIPC. alu_a_pc=1 for AUIPC.
  - Branch decision is latched into taken_q at the EX→WB edge. Condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - LW and SW go to MEM; everything else goes to WB.
- MEM:
  - MemRead=1 (LW) or MemWrite=1 (SW), held for every MEM cycle.
  - The wait counter clears on entering MEM.
  - mem_ready=1 → WB next cycle.
  - Otherwise the counter increments. When it equals MEM_TIMEOUT-1 with mem_ready=0 → TRAP.
  - mem_ready=1 in the same cycle as the timeout: ready wins.
- WB: loadPC=1 and retire=1 for exactly one cycle, then go to IF.
  - RegWrite=1 for all opcodes except SW and BRANCH.
  - wb_sel: LW 01; JAL/JALR 10; LUI 11; all others 00.
  - pc_sel: JAL 01; JALR 10; BRANCH 01 if taken_q, else 00; all others 00.
- instret increments on each WB→IF transition and wraps modulo 2^CNT_W.
- TRAP: trap=1 and all strobes 0 (loadPC, RegWrite, MemRead, MemWrite, retire). Stays in TRAP until rst.
- rst asserted mid-instruction (any state): immediate return to IF with all outputs 0. A MEM access in progress is abandoned; no retire and no instret update.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with fetch_stall=0 → states 0,1,2,4,0. ALUCtrl=0010, ALUSrc=1, WB cycle has RegWrite=1, wb_sel=00, pc_sel=00, retire=1. instret=1.
- BNE with zero=0 in EX → pc_sel=01 in WB. Repeat with zero=1 → pc_sel=00. BGEU with ltu=0 → taken (pc_sel=01).
- LW with mem_ready low for 3 MEM cycles, then high → MemRead=1 for 4 cycles, then WB with wb_sel=01. Total 7 cycles IF→IF.
- SW with mem_ready held 0 and MEM_TIMEOUT=15 → TRAP after 15 MEM cycles. MemWrite drops, trap=1, state=7 until rst.
- Opcode 0x0000007F → ID→TRAP with no retire. rst asserted during MEM → state=0 and all strobes 0 immediately.
- JALR → ALUSrc=1, wb_sel=10, pc_sel=10. With CNT_W=4, 16 retirements → instret wraps to 0.
